// File: rtl/wbuf_alloc_ctrl_pkg.sv
// Shared types and sizing helpers for the write-buffer ID allocator.
package wbuf_alloc_ctrl_pkg;

    typedef struct packed {
        int WbufSize;
        int NumReq;
    } mpc_cfg_t;

    localparam mpc_cfg_t DefaultCfg = '{WbufSize: 16, NumReq: 4};

    // Entry-ID type shared with the write buffer at the default configuration.
    typedef logic [$clog2(DefaultCfg.WbufSize)-1:0] wbufWidth_t;

    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

    // A single requester still needs a one-bit pointer field; it is held at zero.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/wbuf_alloc_ctrl_if.sv
// Allocation request/grant and free-return handshake between requesters and the allocator.
interface wbuf_alloc_ctrl_if
    import wbuf_alloc_ctrl_pkg::*;
#(
    parameter int WbufSize  = DefaultCfg.WbufSize,
    parameter int NumReq    = DefaultCfg.NumReq,
    parameter int WbufWidth = $clog2(WbufSize)
) ();

    logic [NumReq-1:0]    req_valid;
    logic [NumReq-1:0]    req_ready;
    logic [WbufWidth-1:0] alloc_id;
    logic                 free_valid;
    logic [WbufWidth-1:0] free_id;

    modport master (
        output req_valid,
        output free_valid,
        output free_id,
        input  req_ready,
        input  alloc_id
    );

    modport slave (
        input  req_valid,
        input  free_valid,
        input  free_id,
        output req_ready,
        output alloc_id
    );

endinterface

// File: rtl/wbuf_alloc_ctrl_chk.sv
// Runtime checks on allocator state: count matches map population, grant is one-hot-or-zero.
module wbuf_alloc_ctrl_chk #(
    parameter int WbufSize = 16,
    parameter int CntWidth = 5,
    parameter int NumReq   = 4
) (
    input logic                clk,
    input logic                rst,
    input logic [WbufSize-1:0] free_map,
    input logic [CntWidth-1:0] free_cnt,
    input logic [NumReq-1:0]   req_ready
);

    a_cnt_matches_map: assert property (@(posedge clk) disable iff (rst)
        free_cnt == CntWidth'($countones(free_map)));

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

endmodule

// File: rtl/wbuf_alloc_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module wbuf_rr_arb
    import wbuf_alloc_ctrl_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int PtrWidth = ptr_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [PtrWidth-1:0] ptr,
    input  logic                en,
    output logic [NumReq-1:0]   gnt,
    output logic [PtrWidth-1:0] idx
);

    logic any_s;

    // Walk candidates from farthest to nearest so the nearest to ptr wins.
    always_comb begin
        idx   = '0;
        any_s = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx   = (en && req[(int'(ptr) + k) % NumReq]) ? PtrWidth'((int'(ptr) + k) % NumReq) : idx;
            any_s = any_s | (en & req[(int'(ptr) + k) % NumReq]);
        end
        gnt = any_s ? (NumReq'(1) << idx) : '0;
    end

endmodule

// File: rtl/wbuf_alloc_ctrl.sv
// Free-list manager for write-buffer entry IDs: round-robin grant of the lowest free ID,
// reclaim on free-return, sticky double-free detection.
module wbuf_alloc_ctrl
    import wbuf_alloc_ctrl_pkg::*;
#(
    parameter int WbufSize  = DefaultCfg.WbufSize,
    parameter int NumReq    = DefaultCfg.NumReq,
    parameter int WbufWidth = $clog2(WbufSize),
    parameter int CntWidth  = cnt_width(WbufSize)
) (
    input  logic                clk,
    input  logic                rst,
    wbuf_alloc_ctrl_if.slave    bus,
    output logic [CntWidth-1:0] free_cnt,
    output logic                idle,
    output logic                err_double_free
);

    localparam int PtrWidth = ptr_width(NumReq);

    logic [WbufSize-1:0]  free_map_r;
    logic [CntWidth-1:0]  free_cnt_r;
    logic [PtrWidth-1:0]  rr_ptr_r;
    logic                 err_r;
    logic                 idle_r;

    logic [NumReq-1:0]    gnt_s;
    logic [PtrWidth-1:0]  gnt_idx_s;
    logic [WbufWidth-1:0] alloc_id_s;
    logic                 hs_s;
    logic                 legal_free_s;
    logic                 dbl_free_s;
    logic [WbufSize-1:0]  alloc_mask_s;
    logic [WbufSize-1:0]  free_mask_s;
    logic [WbufSize-1:0]  free_map_nxt_s;
    logic [CntWidth-1:0]  free_cnt_nxt_s;
    logic [PtrWidth-1:0]  rr_ptr_nxt_s;

    // Arbitration only sees registered state, so free inputs never reach req_ready.
    wbuf_rr_arb #(
        .NumReq   (NumReq),
        .PtrWidth (PtrWidth)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr_r),
        .en  (|free_map_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s)
    );

    // Lowest-index free ID, from the registered map.
    always_comb begin
        alloc_id_s = '0;
        for (int i = WbufSize - 1; i >= 0; i--) begin
            alloc_id_s = free_map_r[i] ? WbufWidth'(i) : alloc_id_s;
        end
    end

    // Next-state for map, count and pointer; a free of an already-free ID is ignored.
    always_comb begin
        hs_s           = |(gnt_s & bus.req_valid);
        legal_free_s   = bus.free_valid & ~free_map_r[bus.free_id];
        dbl_free_s     = bus.free_valid &  free_map_r[bus.free_id];
        alloc_mask_s   = hs_s ? (WbufSize'(1) << alloc_id_s) : '0;
        free_mask_s    = legal_free_s ? (WbufSize'(1) << bus.free_id) : '0;
        free_map_nxt_s = (free_map_r & ~alloc_mask_s) | free_mask_s;
        free_cnt_nxt_s = free_cnt_r - CntWidth'(hs_s) + CntWidth'(legal_free_s);
        rr_ptr_nxt_s   = hs_s ? PtrWidth'((int'(gnt_idx_s) + 1) % NumReq) : rr_ptr_r;
    end

    // State registers with synchronous reset returning every ID to the pool.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_map_r <= '1;
            free_cnt_r <= CntWidth'(WbufSize);
            rr_ptr_r   <= '0;
            err_r      <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            free_map_r <= free_map_nxt_s;
            free_cnt_r <= free_cnt_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            err_r      <= err_r | dbl_free_s;
            idle_r     <= (free_cnt_nxt_s == CntWidth'(WbufSize));
        end
    end

    assign bus.req_ready    = gnt_s;
    assign bus.alloc_id     = alloc_id_s;
    assign free_cnt         = free_cnt_r;
    assign idle             = idle_r;
    assign err_double_free  = err_r;

    wbuf_alloc_ctrl_chk #(
        .WbufSize (WbufSize),
        .CntWidth (CntWidth),
        .NumReq   (NumReq)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .free_map  (free_map_r),
        .free_cnt  (free_cnt_r),
        .req_ready (gnt_s)
    );

endmodule

// File: tb/tb_wbuf_alloc_ctrl.sv
// Table-driven bench for wbuf_alloc_ctrl with hand-written reset sequences.
module tb_wbuf_alloc_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] free_cnt;
    logic       idle;
    logic       err_double_free;
    int         n_cmp;
    int         n_bad;

    wbuf_alloc_ctrl_if #(.WbufSize(16), .NumReq(4)) bus ();

    wbuf_alloc_ctrl #(.WbufSize(16), .NumReq(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .free_cnt        (free_cnt),
        .idle            (idle),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       fv;
        logic [3:0] fid;
        logic [3:0] rdy;
        bit         chk_id;
        logic [3:0] id;
        logic [4:0] cnt;
        logic       idl;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] req, input logic fv, input logic [3:0] fid,
                                input logic [3:0] rdy, input bit chk_id, input logic [3:0] id,
                                input logic [4:0] cnt, input logic idl, input logic err);
        vec_t v;
        v.req = req; v.fv = fv; v.fid = fid; v.rdy = rdy; v.chk_id = chk_id;
        v.id = id; v.cnt = cnt; v.idl = idl; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        @(negedge clk);
        bus.req_valid  = v.req;
        bus.free_valid = v.fv;
        bus.free_id    = v.fid;
        #1;
        check("req_ready", tag, 32'(bus.req_ready), 32'(v.rdy));
        if (v.chk_id) check("alloc_id", tag, 32'(bus.alloc_id), 32'(v.id));
        check("free_cnt", tag, 32'(free_cnt), 32'(v.cnt));
        check("idle", tag, 32'(idle), 32'(v.idl));
        check("err_double_free", tag, 32'(err_double_free), 32'(v.err));
        @(posedge clk);
    endtask

    task automatic do_reset(input int tag);
        @(negedge clk);
        rst            = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.free_valid = 1'b0;
        bus.free_id    = 4'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_free_cnt", tag, 32'(free_cnt), 32'd16);
        check("rst_idle", tag, 32'(idle), 32'd1);
        check("rst_err", tag, 32'(err_double_free), 32'd0);
        check("rst_req_ready", tag, 32'(bus.req_ready), 32'd0);
    endtask

    int seg1_end;
    int seg2_end;

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.free_valid = 1'b0;
        bus.free_id    = 4'd0;

        // Drain the pool from one requester, then an empty-pool free must not bypass.
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(4'b0001, 1'b0, 4'd0, 4'b0001, 1'b1, 4'(k), 5'(16 - k), (k == 0), 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 4'd5, 4'b0000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd5, 5'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0));
        seg1_end = vecs.size();

        // All four requesting: rotation 0,1,2,3,0,1 with ascending IDs.
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd0, 5'd16, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd1, 5'd15, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0100, 1'b1, 4'd2, 5'd14, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b1000, 1'b1, 4'd3, 5'd13, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd4, 5'd12, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd5, 5'd11, 1'b0, 1'b0));
        seg2_end = vecs.size();

        // After mid-operation reset: pointer back at 0, then grant+free and double-free cases.
        vecs.push_back(mk(4'b1111, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd0, 5'd16, 1'b1, 1'b0));
        for (int k = 1; k <= 13; k++)
            vecs.push_back(mk(4'b0001, 1'b0, 4'd0, 4'b0001, 1'b1, 4'(k), 5'(16 - k), 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 4'd9,  4'b0001, 1'b1, 4'd14, 5'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 4'd0,  4'b0001, 1'b1, 4'd9,  5'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 4'd15, 4'b0001, 1'b1, 4'd15, 5'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 4'd0,  4'b0000, 1'b0, 4'd0,  5'd0, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 4'd3,  4'b0000, 1'b0, 4'd0,  5'd0, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 4'd3,  4'b0000, 1'b0, 4'd0,  5'd1, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 4'd0,  4'b0001, 1'b1, 4'd3,  5'd1, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 4'd0,  4'b0000, 1'b0, 4'd0,  5'd0, 1'b0, 1'b1));

        do_reset(1000);
        for (int i = 0; i < seg1_end; i++) run_vec(vecs[i], i);
        do_reset(1001);
        for (int i = seg1_end; i < seg2_end; i++) run_vec(vecs[i], i);
        do_reset(1002);
        for (int i = seg2_end; i < vecs.size(); i++) run_vec(vecs[i], i);
        do_reset(1003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wbuf_alloc_ctrl.md
Name: wbuf_alloc_ctrl

Overview:
Free-list manager and arbiter for write-buffer entry IDs. It owns the pool of `WbufSize` entry IDs and shares it between `NumReq` requesters (xbar ingress ports) using round-robin arbitration, granting one ID per cycle. It reclaims IDs from the write buffer's free-response path (`xbar_rsp_free_valid`/`xbar_rsp_free_id`). The granted ID is the `wbuf_id` the requester later places in its `wbuf_req_t` enqueue.

Parameters:
- `WbufSize`, default 16: number of write-buffer entries; power of 2, ≥2.
- `NumReq`, default 4: number of requesters, ≥1.
- `WbufWidth`, default $clog2(WbufSize): ID width.
- `CntWidth`, default $clog2(WbufSize+1): free-count width.

Ports:
- `clk` input 1: clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous active-high reset.
- `req_valid` input NumReq: per-requester allocation request.
- `req_ready` output NumReq: one-hot-or-zero grant; handshake when valid&ready.
- `alloc_id` output WbufWidth: ID granted this cycle; meaningful only when |req_ready.
- `free_valid` input 1: ID returned by the write buffer.
- `free_id` input WbufWidth: returned ID.
- `free_cnt` output CntWidth: registered count of free IDs.
- `idle` output 1: all IDs free (free_cnt==WbufSize).
- `err_double_free` output 1: sticky; a free arrived for an ID already free.

Behaviour:
- State:
  - `free_map` [WbufSize], 1 = free.
  - `free_cnt`.
  - `rr_ptr` [$clog2(NumReq)], forced 0 when NumReq==1.
  - `err_double_free`.
- Reset: free_map all ones; free_cnt=WbufSize; rr_ptr=0; err_double_free=0. Outputs after reset: req_ready=0 unless requested, idle=1, err=0.
- Grant is combinational, zero latency.
  - If free_map != 0, pick the first asserted `req_valid` searching from rr_ptr upward with wrap. Only that bit of req_ready is 1.
  - alloc_id = lowest-index set bit of the registered free_map.
- Empty pool (free_map==0): req_ready=0 for all requesters. A free arriving this cycle does NOT bypass to a grant; the freed ID is grantable from the next cycle.
- req_ready never depends on `free_valid`/`free_id` (no combinational path from free inputs to outputs).
- Clock-edge update:
  - On handshake: clear free_map[alloc_id]; rr_ptr <= (granted index + 1) mod NumReq.
  - Without handshake, rr_ptr holds.
  - On a legal free (free_map[free_id]==0): set free_map[free_id].
  - On an illegal free (bit already 1, including free_id==alloc_id in the same cycle): map bit unchanged, err_double_free<=1 (sticky until rst). The concurrent allocation still completes.
  - free_cnt <= free_cnt − handshake + legal_free. Simultaneous grant and legal free leaves the count unchanged.
- free_id ≥ WbufSize cannot occur when WbufSize is a power of 2.
- Invariant: free_cnt == popcount(free_map) at all times. Verification asserts this every cycle.
- Requesters may drop req_valid without a grant; no state is kept per requester.
- Reset mid-operation: all IDs are returned to the pool immediately. Outstanding IDs held by requesters are considered lost, and the system resets the write buffer together with this block.

Decomposition:
- `mpc_types` package: add `WbufSize`/`NumReq` fields to the existing config struct. Add typedef `wbufWidth_t` (reused by the write buffer), and the constant/function for `CntWidth`.
- Sub-module `wbuf_rr_arb`:
  - Inputs: NumReq-wide request vector, rr_ptr, enable (=|free_map).
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; unit-tested separately.
- Lowest-set-bit selection uses the existing priority-encoder/one-hot helpers. No new primitive is added.

Test Plan:
- Reset, then req_valid=4'b0001 for 16 cycles → alloc_id = 0,1,…,15 on consecutive cycles. free_cnt decrements 16→0. Cycle 17: req_ready=0, idle=0.
- Pool empty; free_valid=1, free_id=5 with req_valid=1 the same cycle → no grant that cycle. Next cycle req_ready[0]=1, alloc_id=5, free_cnt 1→0.
- req_valid=4'b1111 held, pool full → grants go to requester 0,1,2,3,0 in order, with alloc_id 0,1,2,3,4.
- With 2 free IDs: grant and a legal free (id 9) in the same cycle → free_cnt unchanged, free_map bit 9 set, allocated bit cleared.
- free_id=3 while ID 3 is already free → err_double_free=1 next cycle and stays 1. free_cnt and free_map are unchanged; a concurrent grant completes normally.
- Allocate 6 IDs, assert rst for one cycle → next cycle free_cnt=16, idle=1, err=0, rr_ptr=0, and the next grant gives alloc_id=0 to the lowest requesting index.
